// File: rtl/sprite_blitter.sv
// Sprite blitter: fetches a sprite descriptor from the sprite table, then walks it row-major and emits one
// source address and screen (x,y) per pixel over valid/ready. Define SPRITE_CLIP_EN to skip off-screen pixels.
module sprite_blitter #(
  parameter int NUM_SPRITES = 13,
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        start,
  input  logic [5:0]  sprite_id,
  input  logic [9:0]  pos_x,
  input  logic [9:0]  pos_y,
  output logic [5:0]  tbl_id,
  input  logic [44:0] tbl_data,
  output logic        px_valid,
  input  logic        px_ready,
  output logic [24:0] src_addr,
  output logic [9:0]  dst_x,
  output logic [9:0]  dst_y,
  output logic        busy,
  output logic        done,
  output logic        bad_id
);

  // state  | meaning
  // IDLE   | waiting for start; id and position registered on start
  // LOOKUP | id presented to the sprite table
  // LATCH  | table output captured, empty/invalid sprites go straight to DONE
  // RUN    | walking pixels row-major
  // DONE   | one-cycle done (and bad_id) pulse
  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_LATCH, S_RUN, S_DONE} state_t;

  state_t      state, state_d;
  logic [9:0]  org_x, org_y, width, height, row, col;
  logic        bad_q, id_bad, tbl_empty, last_px, skip, advance;

  assign id_bad    = tbl_id >= 6'(NUM_SPRITES);
  assign tbl_empty = (tbl_data[19:10] == 10'd0) || (tbl_data[9:0] == 10'd0);
  assign last_px   = (row == height - 10'd1) && (col == width - 10'd1);

`ifdef SPRITE_CLIP_EN
  logic [10:0] sum_x, sum_y;
  assign sum_x = {1'b0, org_x} + {1'b0, col};
  assign sum_y = {1'b0, org_y} + {1'b0, row};
  assign skip  = (sum_x >= 11'(SCREEN_W)) || (sum_y >= 11'(SCREEN_H));
  assign dst_x = sum_x[9:0];
  assign dst_y = sum_y[9:0];
`else
  assign skip  = 1'b0;
  assign dst_x = org_x + col;
  assign dst_y = org_y + row;
`endif

  // Clipped pixels advance without a handshake so the walk stays one step per cycle.
  assign px_valid = (state == S_RUN) && !skip;
  assign advance  = (state == S_RUN) && (px_ready || skip);
  assign busy     = state != S_IDLE;
  assign done     = state == S_DONE;
  assign bad_id   = done && bad_q;

  always_ff @(posedge Clk) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:   if (start) state_d = S_LOOKUP;
      S_LOOKUP: state_d = S_LATCH;
      S_LATCH:  state_d = (id_bad || tbl_empty) ? S_DONE : S_RUN;
      S_RUN:    if (advance && last_px) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      tbl_id   <= '0;
      org_x    <= '0;
      org_y    <= '0;
      width    <= '0;
      height   <= '0;
      row      <= '0;
      col      <= '0;
      src_addr <= '0;
      bad_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          tbl_id <= sprite_id;
          org_x  <= pos_x;
          org_y  <= pos_y;
          row    <= '0;
          col    <= '0;
          bad_q  <= 1'b0;
        end
        S_LATCH: begin
          src_addr <= tbl_data[44:20];
          width    <= tbl_data[19:10];
          height   <= tbl_data[9:0];
          row      <= '0;
          col      <= '0;
          bad_q    <= id_bad;
        end
        S_RUN: if (advance) begin
          src_addr <= src_addr + 25'd1;
          if (col == width - 10'd1) begin
            col <= '0;
            row <= row + 10'd1;
          end else begin
            col <= col + 10'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_blitter.sv
// Bench for sprite_blitter: table stub, random back-pressure, and a row-major reference walk.
// Expected pixel lists follow SPRITE_CLIP_EN the same way the design build does.
module tb_sprite_blitter;

  logic        Clk = 1'b0;
  logic        Reset, start, px_ready;
  logic [5:0]  sprite_id, tbl_id;
  logic [9:0]  pos_x, pos_y, dst_x, dst_y;
  logic [44:0] tbl_data;
  logic        px_valid, busy, done, bad_id;
  logic [24:0] src_addr;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit stall_mode = 1'b0;

  logic [44:0] table_mem [0:12];
  logic [44:0] got[$];
  logic [44:0] exp_q[$];
  int          acc_q[$], rise_q[$], done_q[$], badp_q[$];
  int          s_cyc, g0, a0, r0, d0, b0;
  int          stall_err = 0;
  logic        prev_valid = 1'b0, stalled_prev = 1'b0;
  logic [44:0] prev_pix = '0;

  sprite_blitter dut (
    .Clk(Clk), .Reset(Reset), .start(start), .sprite_id(sprite_id),
    .pos_x(pos_x), .pos_y(pos_y), .tbl_id(tbl_id), .tbl_data(tbl_data),
    .px_valid(px_valid), .px_ready(px_ready), .src_addr(src_addr),
    .dst_x(dst_x), .dst_y(dst_y), .busy(busy), .done(done), .bad_id(bad_id)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc++;

  initial begin
    table_mem[0] = {25'd0, 10'd1, 10'd1};
    table_mem[1] = {25'd310272, 10'd60, 10'd64};
    table_mem[2] = {25'd307200, 10'd640, 10'd480};
    table_mem[3] = {25'd1000, 10'd64, 10'd40};
    table_mem[4] = {25'd5000, 10'd0, 10'd7};
    for (int i = 5; i < 13; i++) table_mem[i] = {25'd100, 10'd3, 10'd2};
  end

  // Registered sprite table; ids with no entry return garbage.
  always @(posedge Clk) begin
    if (tbl_id < 6'd13) tbl_data <= table_mem[tbl_id[3:0]];
    else                tbl_data <= 45'({$urandom, $urandom});
  end

  always @(posedge Clk) begin
    #1;
    px_ready = stall_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
  end

  always @(negedge Clk) begin
    if (stalled_prev && ({px_valid, src_addr, dst_x, dst_y} !== {1'b1, prev_pix})) stall_err++;
    if (px_valid && px_ready) begin
      got.push_back({src_addr, dst_x, dst_y});
      acc_q.push_back(cyc);
    end
    if (px_valid && !prev_valid) rise_q.push_back(cyc);
    if (done) done_q.push_back(cyc);
    if (bad_id) badp_q.push_back(cyc);
    prev_valid   = px_valid;
    stalled_prev = px_valid && !px_ready && !Reset;
    prev_pix     = {src_addr, dst_x, dst_y};
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic int q_at(input int q[$], input int i);
    return (q.size() > i) ? q[i] : -1;
  endfunction

  function automatic logic [44:0] gat(input int i);
    return (got.size() > i) ? got[i] : 45'd0;
  endfunction

  // Reference walk: pixel (r,c) reads base + r*w + c and lands at (px+c, py+r).
  task automatic build(input int base, input int w, input int h, input int px, input int py, input int maxn);
    exp_q.delete();
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++) begin
        if (exp_q.size() >= maxn) return;
`ifdef SPRITE_CLIP_EN
        if (px + c >= 640 || py + r >= 480) continue;
`endif
        exp_q.push_back({25'(base + r * w + c), 10'(px + c), 10'(py + r)});
      end
  endtask

  task automatic cmp_pix(input string tag, input bit prefix);
    int n;
    int b;
    n = got.size() - g0;
    if (!prefix) chk({tag, "_count"}, n, exp_q.size());
    for (int i = 0; i < n && i < exp_q.size(); i++) begin
      b = bad;
      chk({tag, "_pix"}, got[g0 + i], exp_q[i]);
      if (bad != b) break;
    end
  endtask

  task automatic start_blit(input logic [5:0] id, input logic [9:0] x, input logic [9:0] y);
    @(posedge Clk); #1;
    start = 1'b1; sprite_id = id; pos_x = x; pos_y = y;
    s_cyc = cyc;
    g0 = got.size(); a0 = acc_q.size(); r0 = rise_q.size();
    d0 = done_q.size(); b0 = badp_q.size();
    @(posedge Clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit noise);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (noise) begin
        start     = ($urandom_range(0, 3) == 0);
        sprite_id = 6'($urandom);
        pos_x     = 10'($urandom);
      end
      @(negedge Clk); #1;
      if (done_q.size() > d0) begin ok = 1'b1; break; end
      @(posedge Clk); #1;
    end
    start = 1'b0;
    chk("done_timeout", ok, 1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [44:0] t;
    int oob;
    Reset = 1'b1; start = 1'b0; sprite_id = '0; pos_x = '0; pos_y = '0;
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b0;
    @(negedge Clk); #1;
    chk("rst_ctl", {px_valid, busy, done, bad_id}, 0);
    chk("rst_tbl_id", tbl_id, 0);
    chk("rst_src", src_addr, 0);
    chk("rst_dst", {dst_x, dst_y}, 0);

    // id 1, ready held high
    start_blit(6'd1, 10'd100, 10'd50);
    wait_done(5000, 1'b0);
    build(310272, 60, 64, 100, 50, 1 << 30);
    cmp_pix("id1", 1'b0);
    chk("id1_latency", q_at(rise_q, r0), s_cyc + 3);
    chk("id1_first", gat(g0), {25'd310272, 10'd100, 10'd50});
    chk("id1_pix61", gat(g0 + 60), {25'd310332, 10'd100, 10'd51});
    chk("id1_last", gat(g0 + 3839), {25'd314111, 10'd159, 10'd113});
    chk("id1_done_lat", q_at(done_q, d0), q_at(acc_q, a0 + 3839) + 1);
    chk("id1_rate", q_at(acc_q, a0 + 3839) - q_at(acc_q, a0), 3839);
    chk("id1_bad", badp_q.size() - b0, 0);

    // id 1 with random back-pressure and stray start/id/pos activity
    stall_mode = 1'b1;
    start_blit(6'd1, 10'd100, 10'd50);
    wait_done(20000, 1'b1);
    stall_mode = 1'b0;
    cmp_pix("stall", 1'b0);
    chk("stall_hold", stall_err, 0);
    chk("stall_done_cnt", done_q.size() - d0, 1);

    // invalid id
    start_blit(6'd20, 10'd5, 10'd5);
    wait_done(50, 1'b0);
    chk("id20_pix", got.size() - g0, 0);
    chk("id20_valid", rise_q.size() - r0, 0);
    chk("id20_done", q_at(done_q, d0), s_cyc + 3);
    chk("id20_bad", q_at(badp_q, b0), s_cyc + 3);

    // zero-width entry
    start_blit(6'd4, 10'd5, 10'd5);
    wait_done(50, 1'b0);
    chk("w0_pix", got.size() - g0, 0);
    chk("w0_done", q_at(done_q, d0), s_cyc + 3);
    chk("w0_bad", badp_q.size() - b0, 0);

    // 64x40 sprite straddling the bottom-right screen corner
    start_blit(6'd3, 10'd600, 10'd450);
    wait_done(5000, 1'b0);
    build(1000, 64, 40, 600, 450, 1 << 30);
    cmp_pix("id3", 1'b0);
    oob = 0;
    for (int i = g0; i < got.size(); i++) begin
      t = got[i];
      if (t[19:10] >= 10'd640 || t[9:0] >= 10'd480) oob++;
    end
`ifdef SPRITE_CLIP_EN
    chk("id3_n", got.size() - g0, 1200);
    chk("id3_oob", oob, 0);
`else
    chk("id3_n", got.size() - g0, 2560);
    chk("id3_oob", oob, 1360);
`endif

    // full-screen sprite at (600,450), reset mid-RUN
    start_blit(6'd2, 10'd600, 10'd450);
    repeat (700) @(posedge Clk);
    #1 Reset = 1'b1;
    @(posedge Clk); #1 Reset = 1'b0;
    @(negedge Clk); #1;
    chk("mid_rst_ctl", {px_valid, busy, done, bad_id}, 0);
    chk("mid_rst_tbl_id", tbl_id, 0);
    chk("mid_rst_src", src_addr, 0);
    chk("mid_rst_dst", {dst_x, dst_y}, 0);
    build(307200, 640, 480, 600, 450, 2000);
    cmp_pix("id2_prefix", 1'b1);
`ifdef SPRITE_CLIP_EN
    chk("id2_n", got.size() - g0, 80);
`else
    chk("id2_n", got.size() - g0, 699);
    t = gat(g0 + 423);
    chk("wrap_hi", t[19:10], 1023);
    t = gat(g0 + 424);
    chk("wrap_lo", t[19:10], 0);
`endif
    repeat (5) @(negedge Clk);
    chk("mid_rst_no_done", done_q.size() - d0, 0);

    // fresh blit after the reset
    start_blit(6'd1, 10'd100, 10'd50);
    wait_done(5000, 1'b0);
    build(310272, 60, 64, 100, 50, 1 << 30);
    chk("post_rst_latency", q_at(rise_q, r0), s_cyc + 3);
    chk("post_rst_first", gat(g0), {25'd310272, 10'd100, 10'd50});
    cmp_pix("post_rst", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
